branch_predictor: RTL and testbench



---
 rtl/branch_predictor_pkg.sv | 23 ++
 rtl/branch_predictor_sat_counter2.sv | 33 +++
 rtl/branch_predictor.sv | 109 ++++++++++
 tb/tb_branch_predictor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the BTB branch predictor: 2-bit counter encodings,
// allocation value, PC step and PC index/tag field extraction.
package branch_predictor_pkg;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  localparam int unsigned PC_INC = 4;

  // Word-aligned PCs: bits [1:0] never take part in index or tag.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned index_w);
    return (pc >> 2) & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned index_w,
                                         input int unsigned tag_w);
    return (pc >> (index_w + 2)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down direction counter with synchronous load.
// Load has priority over step; reset value is weakly not-taken.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] ctr
);

  logic [1:0] ctr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q <= CTR_WNT;
    end else if (load) begin
      ctr_q <= load_val;
    end else if (step) begin
      if (up) begin
        if (ctr_q != CTR_ST) ctr_q <= ctr_q + 2'd1;
      end else begin
        if (ctr_q != CTR_SNT) ctr_q <= ctr_q - 2'd1;
      end
    end
  end

  assign ctr = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters: zero-latency
// lookup for the fetch PC, single-port training from the resolve stage.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_is_branch,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr      [ENTRIES];

  logic [INDEX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0]   lk_tag, upd_tag;
  logic               upd_hit;
  logic [ENTRIES-1:0] ctr_step, ctr_load;
  logic [31:0]        stat_br_q, stat_mp_q;

  assign lk_idx  = INDEX_W'(pc_index(32'(if_pc), INDEX_W));
  assign lk_tag  = TAG_W'(pc_tag(32'(if_pc), INDEX_W, TAG_W));
  assign upd_idx = INDEX_W'(pc_index(32'(upd_pc), INDEX_W));
  assign upd_tag = TAG_W'(pc_tag(32'(upd_pc), INDEX_W, TAG_W));

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr[lk_idx][1];
  assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + PC_W'(PC_INC);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    ctr_step = '0;
    ctr_load = '0;
    if (upd_valid && upd_is_branch) begin
      if (upd_hit)        ctr_step[upd_idx] = 1'b1;
      else if (upd_taken) ctr_load[upd_idx] = 1'b1;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    sat_counter2 u_ctr (
      .clk      (clk),
      .reset    (reset),
      .step     (ctr_step[i]),
      .up       (upd_taken),
      .load     (ctr_load[i]),
      .load_val (CTR_ALLOC),
      .ctr      (ctr[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        if (upd_hit) begin
          if (upd_taken) target_q[upd_idx] <= upd_target;
        end else if (upd_taken) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
        end
      end else if (upd_hit) begin
        // A non-branch matching an entry means the entry aliases; drop it.
        valid_q[upd_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (upd_valid && upd_is_branch && (stat_br_q != 32'hFFFF_FFFF))
        stat_br_q <= stat_br_q + 32'd1;
      if (upd_valid && upd_mispredict && (stat_mp_q != 32'hFFFF_FFFF))
        stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a table model of the BTB.
module tb_branch_predictor;

  localparam int ENT = 16;
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_branch, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] stat_branches, stat_mispredicts;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: one row per BTB slot, counters as small integers 0..3.
  bit     m_valid [ENT];
  int     m_tag   [ENT];
  int     m_ctr   [ENT];
  int     m_tgt   [ENT];
  longint m_br, m_mp;

  branch_predictor dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_is_branch    (upd_is_branch),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
    end
    m_br = 0; m_mp = 0;
  endtask

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc / (4 * ENT)) % 256);
  endfunction

  task automatic chk_lookup(input string name);
    int s;
    bit h, t;
    logic [31:0] tg;
    s  = slot_of(if_pc);
    h  = m_valid[s] && (m_tag[s] == tag_of(if_pc));
    t  = h && (m_ctr[s] >= 2);
    tg = t ? 32'(m_tgt[s]) : if_pc + 32'd4;
    chk({name, "_hit"},    32'(pred_hit),   32'(h));
    chk({name, "_taken"},  32'(pred_taken), 32'(t));
    chk({name, "_target"}, pred_target,     tg);
  endtask

  task automatic chk_stats(input string name);
    chk({name, "_br"}, stat_branches,    32'(m_br));
    chk({name, "_mp"}, stat_mispredicts, 32'(m_mp));
  endtask

  task automatic set_upd(input logic br, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic mp);
    upd_valid = 1'b1; upd_is_branch = br; upd_pc = pc;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mp;
  endtask

  // Apply pending update to the model, clock it into the DUT, return to negedge.
  task automatic tick();
    int s, g;
    bit h;
    if (upd_valid && !reset) begin
      s = slot_of(upd_pc);
      g = tag_of(upd_pc);
      h = m_valid[s] && (m_tag[s] == g);
      if (upd_is_branch) begin
        if (h) begin
          m_ctr[s] = upd_taken ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1)
                               : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
          if (upd_taken) m_tgt[s] = int'(upd_target);
        end else if (upd_taken) begin
          m_valid[s] = 1; m_tag[s] = g; m_tgt[s] = int'(upd_target); m_ctr[s] = 2;
        end
        m_br = (m_br >= SAT) ? SAT : m_br + 1;
      end else if (h) begin
        m_valid[s] = 0;
      end
      if (upd_mispredict) m_mp = (m_mp >= SAT) ? SAT : m_mp + 1;
    end
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic upd_tick(input logic br, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic mp);
    set_upd(br, pc, tk, tgt, mp);
    tick();
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    reset = 1'b1; if_pc = 32'h0040_0010;
    upd_valid = 0; upd_is_branch = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_mispredict = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst_hit",    32'(pred_hit),   32'd0);
    chk("rst_taken",  32'(pred_taken), 32'd0);
    chk("rst_target", pred_target,     32'h0040_0014);
    chk("rst_br",     stat_branches,    32'd0);
    chk("rst_mp",     stat_mispredicts, 32'd0);

    // Allocation on a taken miss
    upd_tick(1, 32'h0040_0010, 1, 32'h0040_0000, 1);
    chk("alloc_hit",    32'(pred_hit),   32'd1);
    chk("alloc_taken",  32'(pred_taken), 32'd1);
    chk("alloc_target", pred_target,     32'h0040_0000);

    // Counter walks down, saturates at 00, climbs and saturates at 11
    upd_tick(1, 32'h0040_0010, 0, 32'h0, 1);  chk_lookup("nt1");
    upd_tick(1, 32'h0040_0010, 0, 32'h0, 0);
    chk("nt2_taken",  32'(pred_taken), 32'd0);
    chk("nt2_target", pred_target,     32'h0040_0014);
    upd_tick(1, 32'h0040_0010, 0, 32'h0, 0);  chk_lookup("nt3");
    upd_tick(1, 32'h0040_0010, 1, 32'h0040_0000, 0); chk_lookup("sat_lo");
    for (int k = 0; k < 4; k++) upd_tick(1, 32'h0040_0010, 1, 32'h0040_0000, 0);
    upd_tick(1, 32'h0040_0010, 0, 32'h0, 0);  chk_lookup("sat_hi_1");
    upd_tick(1, 32'h0040_0010, 0, 32'h0, 0);  chk_lookup("sat_hi_2");
    chk_stats("walk");

    // Aliasing: same slot, different tag replaces, then a non-branch invalidates
    upd_tick(1, 32'h0040_0050, 1, 32'h0040_0100, 0);
    chk_lookup("alias_old");
    if_pc = 32'h0040_0050; #1;
    chk_lookup("alias_new");
    upd_tick(0, 32'h0040_0050, 0, 32'h0, 0);
    chk_lookup("alias_inval");

    // Same-cycle update and lookup: old view now, new view next cycle
    if_pc = 32'h0040_0010;
    set_upd(1, 32'h0040_0010, 1, 32'h0040_0200, 0);
    #1;
    chk("rdw_old_hit", 32'(pred_hit), 32'd0);
    tick(); #1;
    chk("rdw_new_hit",    32'(pred_hit), 32'd1);
    chk("rdw_new_target", pred_target,   32'h0040_0200);

    // Randomized training and lookups around a small PC pool to force aliasing
    for (int n = 0; n < 300; n++) begin
      rpc = 32'h0040_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
          | $urandom_range(0, 3);
      set_upd(1'($urandom_range(0, 4) != 0), rpc, 1'($urandom_range(0, 1)),
              32'h0040_0000 | ($urandom & 32'h0000_FFFC), 1'($urandom_range(0, 3) == 0));
      upd_valid = 1'($urandom_range(0, 5) != 0);
      if_pc = ($urandom_range(0, 1) == 1) ? rpc
            : (32'h0040_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
      #1;
      chk_lookup("rnd_pre");
      tick(); #1;
      chk_lookup("rnd_post");
      chk_stats("rnd");
    end

    // Reset mid-stream, with an update pending across the reset edge
    if_pc = 32'h0040_0010;
    set_upd(1, 32'h0040_0010, 1, 32'h0040_0300, 1);
    reset = 1'b1;
    #1;
    m_reset();
    chk("mid_rst_br",  stat_branches,    32'd0);
    chk("mid_rst_mp",  stat_mispredicts, 32'd0);
    chk("mid_rst_hit", 32'(pred_hit),    32'd0);
    tick(); #1;
    chk_lookup("in_rst");
    chk_stats("in_rst");
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if_pc = 32'h0040_0000 | (k << 2) | ($urandom_range(0, 3) << 6);
      #1;
      chk_lookup("post_rst");
    end

    // Statistics saturation from a value forced near the top
    force dut.stat_br_q = 32'hFFFF_FFFE;
    force dut.stat_mp_q = 32'hFFFF_FFFE;
    set_upd(1, 32'h0040_0020, 0, 32'h0, 1);
    tick();
    release dut.stat_br_q;
    release dut.stat_mp_q;
    m_br = SAT; m_mp = SAT;
    upd_tick(1, 32'h0040_0020, 0, 32'h0, 1);
    upd_tick(1, 32'h0040_0020, 0, 32'h0, 1);
    chk("sat_br", stat_branches,    32'hFFFF_FFFF);
    chk("sat_mp", stat_mispredicts, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
